// File: rtl/master_start_pkg.sv
// master_start_pkg: shared widths, FSM states and burst descriptor for master_start
package master_start_pkg;
  localparam int TW = 64;
  localparam int FW = 48;
  localparam int CW = 32;
  localparam logic [1:0] TYPE_NONCOH = 2'd0;
  localparam logic [1:0] TYPE_COH    = 2'd1;
  typedef enum logic [2:0] {IDLE, ARMED, TX, BL1, RX, BL2} ms_state_t;
  typedef struct packed {
    logic [FW-1:0] freq;
    logic [FW-1:0] delta_freq;
    logic [31:0]   delta_rate;
    logic [TW-1:0] time_start;
    logic [15:0]   n_impuls;
    logic [1:0]    type_impulse;
    logic [CW-1:0] ti;
    logic [CW-1:0] tp;
    logic [CW-1:0] tb1;
    logic [CW-1:0] tb2;
  } ms_desc_t;
  // Terminal count of a timed state; a programmed 0 behaves like 1 cycle.
  function automatic logic [CW-1:0] last_cnt(input logic [CW-1:0] v);
    return v == '0 ? '0 : v - 1'b1;
  endfunction
endpackage

// File: rtl/ms_sys_time.sv
// ms_sys_time: free-running system time with T1hz-armed preset and preset-done flag
//   clk_48, rst_n (async, active low)
//   t1hz (level, rising edge used), time_update (preset arm), preset_time
//   sys_time (counter, wraps), update_ok (set by a preset, cleared when time_update drops)
module ms_sys_time
  import master_start_pkg::*;
(
  input  logic          clk_48,
  input  logic          rst_n,
  input  logic          t1hz,
  input  logic          time_update,
  input  logic [TW-1:0] preset_time,
  output logic [TW-1:0] sys_time,
  output logic          update_ok
);
  logic t1hz_d;
  logic preset;
  assign preset = t1hz & ~t1hz_d & time_update;
  always_ff @(posedge clk_48 or negedge rst_n)
    if (!rst_n) begin
      t1hz_d    <= 1'b0;
      sys_time  <= '0;
      update_ok <= 1'b0;
    end else begin
      t1hz_d    <= t1hz;
      sys_time  <= preset ? preset_time : sys_time + 1'b1;
      update_ok <= time_update & (update_ok | preset);
    end
endmodule

// File: rtl/master_start.sv
// master_start: radar burst synchronizer, starts DDS and Ti/Tp window sequence at a programmed system time
//   CLK, RESET (async, active low); SYS_TIME/SYS_TIME_UPDATE/T1hz preset system time
//   WR_DATA rising edge latches MEM_* descriptor; DDS_* registered DDS parameters, DDS_start pulse
//   SYS_TIME_UPDATE_OK preset done; En_Iz transmit window; En_Pr receive window
//   MS_LATE_START_EN: a descriptor whose start time already passed starts on the next cycle
module master_start
  import master_start_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic [TW-1:0] SYS_TIME,
  input  logic          SYS_TIME_UPDATE,
  input  logic          T1hz,
  input  logic          WR_DATA,
  input  logic [FW-1:0] MEM_DDS_freq,
  input  logic [FW-1:0] MEM_DDS_delta_freq,
  input  logic [31:0]   MEM_DDS_delta_rate,
  input  logic [TW-1:0] MEM_TIME_START,
  input  logic [15:0]   MEM_N_impuls,
  input  logic [1:0]    MEM_TYPE_impulse,
  input  logic [CW-1:0] MEM_Interval_Ti,
  input  logic [CW-1:0] MEM_Interval_Tp,
  input  logic [CW-1:0] MEM_Tblank1,
  input  logic [CW-1:0] MEM_Tblank2,
  output logic [FW-1:0] DDS_freq,
  output logic [FW-1:0] DDS_delta_freq,
  output logic [31:0]   DDS_delta_rate,
  output logic          DDS_start,
  output logic          SYS_TIME_UPDATE_OK,
  output logic          En_Iz,
  output logic          En_Pr
);
  ms_state_t     state, state_nxt;
  ms_desc_t      desc, mem;
  logic [TW-1:0] sys_time;
  logic [CW-1:0] cnt, lim;
  logic [15:0]   pulses;
  logic          wr_d, latch, hit, go, done, more;
  ms_sys_time u_sys_time (
    .clk_48      (CLK),
    .rst_n       (RESET),
    .t1hz        (T1hz),
    .time_update (SYS_TIME_UPDATE),
    .preset_time (SYS_TIME),
    .sys_time    (sys_time),
    .update_ok   (SYS_TIME_UPDATE_OK)
  );
  assign mem = {MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate, MEM_TIME_START, MEM_N_impuls,
                MEM_TYPE_impulse, MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2};
  assign latch = WR_DATA & ~wr_d & (state == IDLE || state == ARMED);
`ifdef MS_LATE_START_EN
  logic late;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) late <= 1'b0;
    else late <= (state_nxt == ARMED) & (latch ? sys_time > MEM_TIME_START : late);
  assign hit = sys_time == desc.time_start || late;
`else
  assign hit = sys_time == desc.time_start;
`endif
  // A fresh descriptor write wins over a start match in the same cycle.
  assign go   = state == ARMED && hit && !latch && desc.n_impuls != '0;
  assign lim  = state == TX ? last_cnt(desc.ti) : state == BL1 ? last_cnt(desc.tb1) :
                state == RX ? last_cnt(desc.tp) : last_cnt(desc.tb2);
  assign done = cnt == lim;
  assign more = pulses + 16'd1 < desc.n_impuls;
  always_comb begin
    state_nxt = state;
    if (latch) state_nxt = ARMED;
    else
      case (state)
        ARMED: if (hit) state_nxt = desc.n_impuls == '0 ? IDLE : TX;
        TX:    if (done) state_nxt = BL1;
        BL1:   if (done) state_nxt = RX;
        RX:    if (done) state_nxt = BL2;
        BL2:   if (done) state_nxt = more ? TX : IDLE;
        default: ;
      endcase
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state          <= IDLE;
      desc           <= '0;
      cnt            <= '0;
      pulses         <= '0;
      wr_d           <= 1'b0;
      DDS_freq       <= '0;
      DDS_delta_freq <= '0;
      DDS_delta_rate <= '0;
    end else begin
      state  <= state_nxt;
      wr_d   <= WR_DATA;
      cnt    <= state_nxt != state ? '0 : cnt + 1'b1;
      pulses <= go ? '0 : (state == BL2 && done) ? pulses + 16'd1 : pulses;
      if (latch) desc <= mem;
      if (go) begin
        DDS_freq       <= desc.freq;
        DDS_delta_freq <= desc.delta_freq;
        DDS_delta_rate <= desc.delta_rate;
      end
    end
  assign En_Iz     = state == TX;
  assign En_Pr     = state == RX;
  // Coherent bursts restart the DDS only on the first pulse.
  assign DDS_start = state == TX && cnt == '0 && (desc.type_impulse != TYPE_COH || pulses == '0);
endmodule

// File: tb/tb_master_start.sv
// tb_master_start: self-checking bench for master_start against a schedule-based burst model
module tb_master_start;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [63:0] SYS_TIME = '0;
  logic        SYS_TIME_UPDATE = 1'b0;
  logic        T1hz = 1'b0;
  logic        WR_DATA = 1'b0;
  logic [47:0] MEM_DDS_freq = '0;
  logic [47:0] MEM_DDS_delta_freq = '0;
  logic [31:0] MEM_DDS_delta_rate = '0;
  logic [63:0] MEM_TIME_START = '0;
  logic [15:0] MEM_N_impuls = '0;
  logic [1:0]  MEM_TYPE_impulse = '0;
  logic [31:0] MEM_Interval_Ti = '0;
  logic [31:0] MEM_Interval_Tp = '0;
  logic [31:0] MEM_Tblank1 = '0;
  logic [31:0] MEM_Tblank2 = '0;
  logic [47:0] DDS_freq, DDS_delta_freq;
  logic [31:0] DDS_delta_rate;
  logic        DDS_start, SYS_TIME_UPDATE_OK, En_Iz, En_Pr;

  master_start dut (
    .CLK(CLK), .RESET(RESET), .SYS_TIME(SYS_TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .T1hz(T1hz),
    .WR_DATA(WR_DATA), .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
    .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START), .MEM_N_impuls(MEM_N_impuls),
    .MEM_TYPE_impulse(MEM_TYPE_impulse), .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
    .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2), .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq),
    .DDS_delta_rate(DDS_delta_rate), .DDS_start(DDS_start), .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK),
    .En_Iz(En_Iz), .En_Pr(En_Pr)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // model state: system time, armed descriptor, and the scheduled burst as (start cycle, period)
  longint      cyc = 0;
  logic [63:0] m_time, d_ts;
  bit          m_armed, m_late, m_run, m_ok, m_t1p, m_wrp, m_coh;
  logic [47:0] d_f, d_df, m_f, m_df;
  logic [31:0] d_rate, m_rate, d_ti, d_tb1, d_tp, d_tb2;
  logic [15:0] d_n;
  logic [1:0]  d_type;
  longint      m_start, m_n, m_p, m_di, m_db1, m_dp;

  function automatic longint dur(input logic [31:0] v);
    return v == 0 ? 64'd1 : {32'd0, v};
  endfunction

  function automatic bit busy(input longint c);
    return m_run && c >= m_start && c < m_start + m_n * m_p;
  endfunction

  task automatic mreset();
    m_time = '0; m_armed = 0; m_late = 0; m_run = 0; m_ok = 0; m_t1p = 0; m_wrp = 0;
    m_f = '0; m_df = '0; m_rate = '0;
  endtask

  task automatic mstep();
    longint cur;
    bit pre, wr;
    cur = cyc;
    pre = T1hz && !m_t1p && SYS_TIME_UPDATE;
    wr  = WR_DATA && !m_wrp;
    if (wr && !busy(cur)) begin
      d_f = MEM_DDS_freq; d_df = MEM_DDS_delta_freq; d_rate = MEM_DDS_delta_rate; d_ts = MEM_TIME_START;
      d_n = MEM_N_impuls; d_type = MEM_TYPE_impulse; d_ti = MEM_Interval_Ti; d_tp = MEM_Interval_Tp;
      d_tb1 = MEM_Tblank1; d_tb2 = MEM_Tblank2; m_armed = 1;
`ifdef MS_LATE_START_EN
      m_late = m_time > MEM_TIME_START;
`else
      m_late = 0;
`endif
    end else if (m_armed && (m_time == d_ts || m_late)) begin
      m_armed = 0; m_late = 0;
      if (d_n != 0) begin
        m_run = 1; m_start = cur + 1; m_n = longint'(d_n);
        m_di = dur(d_ti); m_db1 = dur(d_tb1); m_dp = dur(d_tp);
        m_p = m_di + m_db1 + m_dp + dur(d_tb2);
        m_coh = d_type == 2'd1;
        m_f = d_f; m_df = d_df; m_rate = d_rate;
      end
    end
    m_time = pre ? SYS_TIME : m_time + 64'd1;
    m_ok   = SYS_TIME_UPDATE && (m_ok || pre);
    m_t1p  = T1hz; m_wrp = WR_DATA;
    cyc    = cur + 1;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) mreset();
      else mstep();
    end
  end

  // activity monitor for hand-computed checks
  longint n_iz = 0, n_pr = 0, n_st = 0, n_rise = 0, rise_cyc = 0, fall_cyc = 0, pr_rise_cyc = 0;
  bit iz_prev = 0, pr_prev = 0;

  always @(negedge CLK) begin
    longint off, k, ph;
    bit e_iz, e_pr, e_st;
    e_iz = 0; e_pr = 0; e_st = 0;
    if (busy(cyc)) begin
      off = cyc - m_start; k = off / m_p; ph = off % m_p;
      e_iz = ph < m_di;
      e_pr = ph >= m_di + m_db1 && ph < m_di + m_db1 + m_dp;
      e_st = ph == 0 && (!m_coh || k == 0);
    end
    checks++;
    if ({En_Iz, En_Pr, DDS_start, SYS_TIME_UPDATE_OK} == {e_iz, e_pr, e_st, m_ok} &&
        DDS_freq == m_f && DDS_delta_freq == m_df && DDS_delta_rate == m_rate)
      passes++;
    else
      $display("FAIL cycle %0d outputs: iz/pr/st/ok got %b%b%b%b expected %b%b%b%b, freq/dfreq/rate got %h/%h/%h expected %h/%h/%h",
               cyc, En_Iz, En_Pr, DDS_start, SYS_TIME_UPDATE_OK, e_iz, e_pr, e_st, m_ok,
               DDS_freq, DDS_delta_freq, DDS_delta_rate, m_f, m_df, m_rate);
    n_iz += longint'(En_Iz); n_pr += longint'(En_Pr); n_st += longint'(DDS_start);
    if (En_Iz && !iz_prev) begin n_rise++; rise_cyc = cyc; end
    if (!En_Iz && iz_prev) fall_cyc = cyc;
    if (En_Pr && !pr_prev) pr_rise_cyc = cyc;
    iz_prev = En_Iz; pr_prev = En_Pr;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic set_desc(input logic [63:0] ts, input int n, input int ty, input int ti, input int tb1,
                          input int tp, input int tb2, input logic [47:0] f);
    MEM_TIME_START = ts; MEM_N_impuls = 16'(n); MEM_TYPE_impulse = 2'(ty);
    MEM_Interval_Ti = 32'(ti); MEM_Tblank1 = 32'(tb1); MEM_Interval_Tp = 32'(tp); MEM_Tblank2 = 32'(tb2);
    MEM_DDS_freq = f; MEM_DDS_delta_freq = 48'h100000; MEM_DDS_delta_rate = 32'h100;
  endtask

  task automatic wr_pulse();
    WR_DATA = 1'b1;
    step(1);
    WR_DATA = 1'b0;
  endtask

  initial begin
    longint t0, c, iz0, pr0, st0, r0;
    step(2);
    chk("reset En_Iz", longint'(En_Iz), 0);
    chk("reset En_Pr", longint'(En_Pr), 0);
    chk("reset DDS_start", longint'(DDS_start), 0);
    chk("reset OK", longint'(SYS_TIME_UPDATE_OK), 0);
    chk("reset DDS_freq", longint'(DDS_freq), 0);
    RESET = 1'b1;
    step(3);
    // preset system time to 0
    SYS_TIME = '0; SYS_TIME_UPDATE = 1'b1; T1hz = 1'b1;
    step(1);
    t0 = cyc;
    chk("preset OK set", longint'(SYS_TIME_UPDATE_OK), 1);
    T1hz = 1'b0;
    step(2);
    SYS_TIME_UPDATE = 1'b0;
    step(1);
    chk("preset OK cleared", longint'(SYS_TIME_UPDATE_OK), 0);
    // single long pulse at TIME_START 0x12C0
    set_desc(64'h12C0, 1, 0, 32'h1800, 32'h180, 32'h1800, 32'h180, 48'h1000000000);
    iz0 = n_iz; pr0 = n_pr; st0 = n_st;
    wr_pulse();
    step(18000);
    chk("single start cycle", rise_cyc - t0, 4801);
    chk("single Ti cycles", n_iz - iz0, 6144);
    chk("single Tp cycles", n_pr - pr0, 6144);
    chk("single DDS_start", n_st - st0, 1);
    chk("single blank1 gap", pr_rise_cyc - fall_cyc, 384);
    chk("single DDS_freq", longint'(DDS_freq), 64'h1000000000);
    chk("single DDS_delta_freq", longint'(DDS_delta_freq), 64'h100000);
    chk("single DDS_delta_rate", longint'(DDS_delta_rate), 64'h100);
    // N=3 non-coherent, with an ignored write during TX
    iz0 = n_iz; pr0 = n_pr; st0 = n_st; r0 = n_rise;
    set_desc(m_time + 10, 3, 0, 5, 2, 4, 3, 48'h1000000000);
    wr_pulse();
    step(11);
    set_desc(m_time + 3, 1, 0, 1, 1, 1, 1, 48'h5);
    wr_pulse();
    step(60);
    chk("noncoh DDS_start", n_st - st0, 3);
    chk("noncoh Ti windows", n_rise - r0, 3);
    chk("noncoh Ti cycles", n_iz - iz0, 15);
    chk("noncoh Tp cycles", n_pr - pr0, 12);
    chk("ignored wr DDS_freq", longint'(DDS_freq), 64'h1000000000);
    // N=3 coherent
    st0 = n_st; r0 = n_rise;
    set_desc(m_time + 10, 3, 1, 5, 2, 4, 3, 48'h2222);
    wr_pulse();
    step(70);
    chk("coh DDS_start", n_st - st0, 1);
    chk("coh Ti windows", n_rise - r0, 3);
    // zero intervals count as one cycle
    iz0 = n_iz; pr0 = n_pr; st0 = n_st;
    set_desc(m_time + 6, 2, 2, 0, 0, 0, 0, 48'h3333);
    wr_pulse();
    step(30);
    chk("zero Ti cycles", n_iz - iz0, 2);
    chk("zero Tp cycles", n_pr - pr0, 2);
    chk("zero DDS_start", n_st - st0, 2);
    // N=0 never transmits
    iz0 = n_iz;
    set_desc(m_time + 6, 0, 0, 5, 2, 4, 3, 48'h4444);
    wr_pulse();
    step(30);
    chk("N0 Ti cycles", n_iz - iz0, 0);
    // reset in the middle of TX
    set_desc(m_time + 10, 1, 0, 100, 2, 100, 2, 48'h5555);
    wr_pulse();
    step(10);
    chk("pre-reset En_Iz", longint'(En_Iz), 1);
    #1 RESET = 1'b0;
    #1;
    chk("async reset En_Iz", longint'(En_Iz), 0);
    chk("async reset En_Pr", longint'(En_Pr), 0);
    step(2);
    RESET = 1'b1;
    step(20);
    // start time already in the past
    r0 = n_rise; c = cyc;
    set_desc(m_time - 5, 1, 0, 4, 2, 4, 2, 48'h6666);
    wr_pulse();
    step(20);
`ifdef MS_LATE_START_EN
    chk("late start windows", n_rise - r0, 1);
    chk("late start delay", rise_cyc - c, 2);
`else
    chk("late start windows", n_rise - r0, 0);
    chk("late start En_Iz", longint'(En_Iz), 0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
